// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Opcodes, ALU op classes, control bundle and decoder for the MIPS core
// Rev    : 1.0
// ============================================================================
package mips_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module : decode_stage_if
// Brief  : Fetch/write-back inputs and ID/EX outputs of the decode stage
// Rev    : 1.0
// ============================================================================
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]                    if_instr;
  logic [DATA_W-1:0]              if_pc_plus1;
  logic                           stall;
  logic                           flush;
  logic                           wb_we;
  logic [mips_pkg::REG_IDX_W-1:0] wb_addr;
  logic [DATA_W-1:0]              wb_data;

  logic                           hazard_stall;
  logic                           id_valid;
  logic [DATA_W-1:0]              id_pc_plus1;
  logic [DATA_W-1:0]              id_rs_data;
  logic [DATA_W-1:0]              id_rt_data;
  logic [DATA_W-1:0]              id_imm_ext;
  logic [mips_pkg::REG_IDX_W-1:0] id_rs;
  logic [mips_pkg::REG_IDX_W-1:0] id_rt;
  logic [mips_pkg::REG_IDX_W-1:0] id_rd;
  logic [5:0]                     id_funct;
  logic                           id_reg_dst;
  logic                           id_alu_src;
  logic                           id_mem_to_reg;
  logic                           id_reg_write;
  logic                           id_mem_read;
  logic                           id_mem_write;
  logic                           id_branch;
  logic [1:0]                     id_alu_op;
  logic                           id_illegal;

  modport master (
    output if_instr, if_pc_plus1, stall, flush, wb_we, wb_addr, wb_data,
    input  hazard_stall, id_valid, id_pc_plus1, id_rs_data, id_rt_data,
           id_imm_ext, id_rs, id_rt, id_rd, id_funct, id_reg_dst, id_alu_src,
           id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch,
           id_alu_op, id_illegal
  );

  modport slave (
    input  if_instr, if_pc_plus1, stall, flush, wb_we, wb_addr, wb_data,
    output hazard_stall, id_valid, id_pc_plus1, id_rs_data, id_rt_data,
           id_imm_ext, id_rs, id_rt, id_rd, id_funct, id_reg_dst, id_alu_src,
           id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch,
           id_alu_op, id_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : 32x32 register file, one write port, two write-through read ports
// Rev    : 1.0
// ============================================================================
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 we_i,
  input  wire logic [REG_IDX_W-1:0] waddr_i,
  input  wire logic [DATA_W-1:0]    wdata_i,
  input  wire logic [REG_IDX_W-1:0] raddr_a_i,
  input  wire logic [REG_IDX_W-1:0] raddr_b_i,
  output logic      [DATA_W-1:0]    rdata_a_o,
  output logic      [DATA_W-1:0]    rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // $0 reads zero; a same-cycle write to the read address is forwarded
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (wr_en && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_en && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Brief  : IF/ID register, register file, control decode, load-use detect, ID/EX
// Rev    : 1.0
// ============================================================================
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input wire logic      clk,
  input wire logic      rst_n,
  decode_stage_if.slave bus
);

  logic [31:0]          ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic                 ifid_valid_q, ifid_valid_d;

  logic                 idex_valid_q, idex_valid_d;
  logic [DATA_W-1:0]    idex_pc_q, idex_pc_d;
  logic [DATA_W-1:0]    idex_rs_data_q, idex_rs_data_d;
  logic [DATA_W-1:0]    idex_rt_data_q, idex_rt_data_d;
  logic [DATA_W-1:0]    idex_imm_q, idex_imm_d;
  logic [REG_IDX_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_IDX_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_IDX_W-1:0] idex_rd_q, idex_rd_d;
  logic [5:0]           idex_funct_q, idex_funct_d;
  ctrl_t                idex_ctrl_q, idex_ctrl_d;

  logic [5:0]           w_opcode;
  logic [REG_IDX_W-1:0] w_rs, w_rt, w_rd;
  logic [DATA_W-1:0]    w_imm_ext, w_rs_data, w_rt_data;
  ctrl_t                w_ctrl;
  logic                 w_rt_is_src, w_hazard, w_hold;

  assign w_opcode  = ifid_instr_q[31:26];
  assign w_rs      = ifid_instr_q[25:21];
  assign w_rt      = ifid_instr_q[20:16];
  assign w_rd      = ifid_instr_q[15:11];
  assign w_imm_ext = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
  assign w_ctrl    = ifid_valid_q ? decode_ctrl(w_opcode) : '0;

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (bus.wb_we),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data),
    .raddr_a_i (w_rs),
    .raddr_b_i (w_rt),
    .rdata_a_o (w_rs_data),
    .rdata_b_o (w_rt_data)
  );

  // rt is only a source operand for R-type, sw and beq; lw/addi write it
  assign w_rt_is_src = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);
  assign w_hazard    = idex_valid_q && idex_ctrl_q.mem_read && (idex_rt_q != '0) && ifid_valid_q &&
                       ((idex_rt_q == w_rs) || ((idex_rt_q == w_rt) && w_rt_is_src));
  assign w_hold      = bus.stall || w_hazard;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.flush) begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (!w_hold) begin
      ifid_instr_d = bus.if_instr;
      ifid_pc_d    = bus.if_pc_plus1;
      ifid_valid_d = 1'b1;
    end
  end

  always_comb begin
    idex_valid_d   = 1'b0;
    idex_pc_d      = '0;
    idex_rs_data_d = '0;
    idex_rt_data_d = '0;
    idex_imm_d     = '0;
    idex_rs_d      = '0;
    idex_rt_d      = '0;
    idex_rd_d      = '0;
    idex_funct_d   = '0;
    idex_ctrl_d    = '0;
    if (!bus.flush && !w_hold) begin
      idex_valid_d   = ifid_valid_q;
      idex_pc_d      = ifid_pc_q;
      idex_rs_data_d = w_rs_data;
      idex_rt_data_d = w_rt_data;
      idex_imm_d     = w_imm_ext;
      idex_rs_d      = w_rs;
      idex_rt_d      = w_rt;
      idex_rd_d      = w_rd;
      idex_funct_d   = ifid_instr_q[5:0];
      idex_ctrl_d    = w_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q   <= '0;
      ifid_pc_q      <= '0;
      ifid_valid_q   <= 1'b0;
      idex_valid_q   <= 1'b0;
      idex_pc_q      <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
      idex_funct_q   <= '0;
      idex_ctrl_q    <= '0;
    end else begin
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_valid_q   <= ifid_valid_d;
      idex_valid_q   <= idex_valid_d;
      idex_pc_q      <= idex_pc_d;
      idex_rs_data_q <= idex_rs_data_d;
      idex_rt_data_q <= idex_rt_data_d;
      idex_imm_q     <= idex_imm_d;
      idex_rs_q      <= idex_rs_d;
      idex_rt_q      <= idex_rt_d;
      idex_rd_q      <= idex_rd_d;
      idex_funct_q   <= idex_funct_d;
      idex_ctrl_q    <= idex_ctrl_d;
    end
  end

  assign bus.hazard_stall  = w_hazard;
  assign bus.id_valid      = idex_valid_q;
  assign bus.id_pc_plus1   = idex_pc_q;
  assign bus.id_rs_data    = idex_rs_data_q;
  assign bus.id_rt_data    = idex_rt_data_q;
  assign bus.id_imm_ext    = idex_imm_q;
  assign bus.id_rs         = idex_rs_q;
  assign bus.id_rt         = idex_rt_q;
  assign bus.id_rd         = idex_rd_q;
  assign bus.id_funct      = idex_funct_q;
  assign bus.id_reg_dst    = idex_ctrl_q.reg_dst;
  assign bus.id_alu_src    = idex_ctrl_q.alu_src;
  assign bus.id_mem_to_reg = idex_ctrl_q.mem_to_reg;
  assign bus.id_reg_write  = idex_ctrl_q.reg_write;
  assign bus.id_mem_read   = idex_ctrl_q.mem_read;
  assign bus.id_mem_write  = idex_ctrl_q.mem_write;
  assign bus.id_branch     = idex_ctrl_q.branch;
  assign bus.id_alu_op     = idex_ctrl_q.alu_op;
  assign bus.id_illegal    = idex_ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_stage
// Brief  : Directed vector table plus hand sequences for the decode stage
// Rev    : 1.0
// ============================================================================
module tb_decode_stage;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_instr    = instr;
    bus.if_pc_plus1 = pc;
  endtask

  function automatic logic [9:0] ctrl_now();
    return {bus.id_reg_dst, bus.id_alu_src, bus.id_mem_to_reg, bus.id_reg_write,
            bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_alu_op, bus.id_illegal};
  endfunction

  initial begin
    // ctrl order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch alu_op[1:0] illegal
    vecs[0] = '{32'h00222020, 32'h100, 10'b1001000100, 32'h00002020, 32'h1001, 32'h1002, 5'd1, 5'd2, 5'd4,  6'h20};
    vecs[1] = '{32'h8CA30008, 32'h101, 10'b0111100000, 32'h00000008, 32'h1005, 32'h1003, 5'd5, 5'd3, 5'd0,  6'h08};
    vecs[2] = '{32'hACE6FFFC, 32'h102, 10'b0100010000, 32'hFFFFFFFC, 32'h1007, 32'h1006, 5'd7, 5'd6, 5'd31, 6'h3C};
    vecs[3] = '{32'h10220010, 32'h103, 10'b0000001010, 32'h00000010, 32'h1001, 32'h1002, 5'd1, 5'd2, 5'd0,  6'h10};
    vecs[4] = '{32'hFC000000, 32'h104, 10'b0000000001, 32'h00000000, 32'h0,    32'h0,    5'd0, 5'd0, 5'd0,  6'h00};
    vecs[5] = '{32'h2001FFFB, 32'h105, 10'b0101000000, 32'hFFFFFFFB, 32'h0,    32'h1001, 5'd0, 5'd1, 5'd31, 6'h3B};

    rst_n       = 1'b0;
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    bus.wb_we   = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    drive(32'h0, 32'h0);
    #2;
    check("reset id_valid", bus.id_valid, 0);
    check("reset hazard_stall", bus.hazard_stall, 0);
    check("reset ctrl", ctrl_now(), 0);
    check("reset id_pc_plus1", bus.id_pc_plus1, 0);

    // addi $1,$0,-5 right after reset release
    tick();
    tick();
    rst_n = 1'b1;
    drive(32'h2001FFFB, 32'h1);
    tick();
    drive(32'h0, 32'h0);
    tick();
    check("addi id_valid", bus.id_valid, 1);
    check("addi id_imm_ext", bus.id_imm_ext, 32'hFFFFFFFB);
    check("addi id_alu_src", bus.id_alu_src, 1);
    check("addi id_reg_write", bus.id_reg_write, 1);
    check("addi id_rt", bus.id_rt, 1);
    check("addi id_pc_plus1", bus.id_pc_plus1, 1);

    // add $4,$3,$3 in IF/ID while $3 is written back
    drive(32'h00632020, 32'h2);
    tick();
    drive(32'h0, 32'h0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
    tick();
    bus.wb_we = 1'b0;
    check("bypass id_rs_data", bus.id_rs_data, 32'hDEADBEEF);
    check("bypass id_rt_data", bus.id_rt_data, 32'hDEADBEEF);
    drive(32'h00632020, 32'h3);
    tick();
    drive(32'h0, 32'h0);
    tick();
    check("stored $3 id_rt_data", bus.id_rt_data, 32'hDEADBEEF);

    // add $4,$0,$0 while write-back targets $0
    drive(32'h00002020, 32'h4);
    tick();
    drive(32'h0, 32'h0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    tick();
    bus.wb_we = 1'b0;
    check("zero reg id_rs_data", bus.id_rs_data, 0);
    check("zero reg id_rt_data", bus.id_rt_data, 0);

    for (int k = 1; k < 8; k++) begin
      bus.wb_we = 1'b1; bus.wb_addr = k[4:0]; bus.wb_data = 32'h1000 + k;
      tick();
    end
    bus.wb_we = 1'b0;

    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(vecs[i].instr, vecs[i].pc);
      else       drive(32'h0, 32'h0);
      tick();
      if (i > 0) begin
        check($sformatf("vec%0d id_valid", i-1), bus.id_valid, 1);
        check($sformatf("vec%0d ctrl", i-1), ctrl_now(), vecs[i-1].ctrl);
        check($sformatf("vec%0d id_imm_ext", i-1), bus.id_imm_ext, vecs[i-1].imm);
        check($sformatf("vec%0d id_rs_data", i-1), bus.id_rs_data, vecs[i-1].rs_data);
        check($sformatf("vec%0d id_rt_data", i-1), bus.id_rt_data, vecs[i-1].rt_data);
        check($sformatf("vec%0d id_rs", i-1), bus.id_rs, vecs[i-1].rs);
        check($sformatf("vec%0d id_rt", i-1), bus.id_rt, vecs[i-1].rt);
        check($sformatf("vec%0d id_rd", i-1), bus.id_rd, vecs[i-1].rd);
        check($sformatf("vec%0d id_funct", i-1), bus.id_funct, vecs[i-1].funct);
        check($sformatf("vec%0d id_pc_plus1", i-1), bus.id_pc_plus1, vecs[i-1].pc);
        check($sformatf("vec%0d hazard_stall", i-1), bus.hazard_stall, 0);
      end
    end

    // lw $2,0($1) then add $5,$2,$2
    drive(32'h8C220000, 32'h200);
    tick();
    drive(32'h00422820, 32'h201);
    tick();
    check("loaduse hazard_stall on", bus.hazard_stall, 1);
    check("loaduse lw mem_read", bus.id_mem_read, 1);
    drive(32'h0, 32'h202);
    tick();
    check("loaduse bubble id_valid", bus.id_valid, 0);
    check("loaduse hazard_stall off", bus.hazard_stall, 0);
    tick();
    check("loaduse add id_valid", bus.id_valid, 1);
    check("loaduse add id_rs", bus.id_rs, 2);
    check("loaduse add id_rd", bus.id_rd, 5);
    check("loaduse add id_pc_plus1", bus.id_pc_plus1, 32'h201);

    // flush with beq in ID/EX and a younger add in IF/ID
    drive(32'h10220010, 32'h300);
    tick();
    drive(32'h00222020, 32'h301);
    tick();
    check("flush beq id_branch", bus.id_branch, 1);
    bus.flush = 1'b1;
    drive(32'h00222020, 32'h302);
    tick();
    bus.flush = 1'b0;
    check("flush id_valid", bus.id_valid, 0);
    check("flush ctrl", ctrl_now(), 0);
    drive(32'h2001FFFB, 32'h303);
    tick();
    check("flush squashed IF/ID id_valid", bus.id_valid, 0);
    drive(32'h0, 32'h0);
    tick();
    check("post-flush id_valid", bus.id_valid, 1);
    check("post-flush id_pc_plus1", bus.id_pc_plus1, 32'h303);

    // external stall for 3 cycles with sw in IF/ID
    drive(32'hACE6FFFC, 32'h400);
    tick();
    bus.stall = 1'b1;
    drive(32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall bubble%0d id_valid", c), bus.id_valid, 0);
      check($sformatf("stall bubble%0d id_mem_write", c), bus.id_mem_write, 0);
    end
    bus.stall = 1'b0;
    tick();
    check("stall sw id_valid", bus.id_valid, 1);
    check("stall sw id_mem_write", bus.id_mem_write, 1);
    check("stall sw id_pc_plus1", bus.id_pc_plus1, 32'h400);
    tick();
    check("stall no duplicate id_mem_write", bus.id_mem_write, 0);

    // asynchronous reset mid-stream
    drive(32'h2001FFFB, 32'h7);
    tick();
    drive(32'h0, 32'h0);
    tick();
    check("pre-reset id_valid", bus.id_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset id_valid", bus.id_valid, 0);
    check("async reset ctrl", ctrl_now(), 0);
    check("async reset id_imm_ext", bus.id_imm_ext, 0);
    check("async reset id_pc_plus1", bus.id_pc_plus1, 0);
    check("async reset id_rt", bus.id_rt, 0);
    tick();
    rst_n = 1'b1;
    drive(32'h00632020, 32'h8);
    tick();
    drive(32'h0, 32'h0);
    tick();
    check("post-reset id_valid", bus.id_valid, 1);
    check("post-reset regfile $3", bus.id_rs_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the MIPS core. Sits directly downstream of the fetch stage and consumes its `instruction` and `adderOutput` (PC+1, word-addressed).
- Contains:
  - the IF/ID pipeline register;
  - the 32x32 register file, with a write-back port;
  - the main control decoder;
  - the sign extender;
  - load-use hazard detection;
  - the ID/EX pipeline register that feeds execute.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 32, register file depth; index width is 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_instr  in  32  instruction from fetch.
- if_pc_plus1  in  32  PC+1 from fetch.
- stall  in  1  external stall: hold IF/ID, inject a bubble into ID/EX.
- flush  in  1  taken branch: squash IF/ID and ID/EX.
- wb_we  in  1  register file write enable from write-back.
- wb_addr  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- hazard_stall  out  1  combinational load-use stall request; fetch must hold its PC.
- id_valid  out  1  ID/EX holds a real instruction.
- id_pc_plus1  out  32  registered PC+1.
- id_rs_data, id_rt_data  out  32 each  registered operands.
- id_imm_ext  out  32  registered sign-extended instr[15:0].
- id_rs, id_rt, id_rd  out  5 each  registered register fields.
- id_funct  out  6  registered instr[5:0].
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  out  1 each  registered controls.
- id_alu_op  out  2  registered ALU op class.
- id_illegal  out  1  registered flag: unsupported opcode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - IF/ID instruction, PC+1 and valid cleared to 0.
  - All ID/EX outputs cleared to 0.
  - All 32 register file entries cleared to 0.
  - hazard_stall is 0 because ID/EX valid is 0.
- Latency: an instruction present on if_instr at edge N is captured into IF/ID at edge N. Its decoded results appear on the id_* outputs after edge N+1.
- IF/ID register:
  - Normal cycle: capture if_instr and if_pc_plus1, set ifid_valid=1.
  - If (stall | hazard_stall) and not flush: hold all IF/ID contents.
  - If flush: clear ifid_valid and the instruction to 0 (a NOP).
- ID/EX register:
  - Normal cycle: load the decoded fields, controls and operands; id_valid = ifid_valid.
  - If flush, stall or hazard_stall: load a bubble (all controls 0, id_valid=0, id_illegal=0). Datapath fields are don't-care and are zeroed.
  - Priority: flush > stall/hazard_stall > normal.
- Decode, applied when ifid_valid=1; otherwise all controls are 0.
  - opcode 0x00 (R-type): reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 (lw): alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 0x2B (sw): alu_src=1, mem_write=1, alu_op=00.
  - 0x04 (beq): branch=1, alu_op=01.
  - 0x08 (addi): alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0 and illegal=1. The instruction still advances with id_valid=1.
- Field extraction: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11]. imm_ext = instr[15:0] sign-extended to 32 bits.
- Register file:
  - Write at the rising edge when wb_we=1 and wb_addr != 0. Writes to $0 are ignored, and $0 always reads 0.
  - Two combinational read ports (rs, rt) with write-through bypass: if wb_we && wb_addr != 0 && wb_addr == read address, the read returns wb_data in the same cycle.
- Load-use hazard:
  - hazard_stall = id_valid & id_mem_read & (id_rt != 0) & ifid_valid & ((id_rt == ifid rs) | (id_rt == ifid rt & ifid opcode in {R-type, sw, beq})).
  - Lasts exactly one cycle per load, because the bubble clears id_mem_read.
- Simultaneous events:
  - flush with hazard_stall or stall: flush wins; hazard_stall is still reported combinationally.
  - Write-back and read of the same register: the new data is seen via the bypass.
- Reset mid-operation: in-flight instructions are discarded with no partial state. The first valid output appears two edges after release.

Decomposition:
- Shared package mips_pkg holds the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), the ALU_OP encodings, and the register index width.
- One natural sub-module, reg_file: 32x32, async reset, one write port, two bypassed read ports, $0 hardwired to zero.
- Control decoder and hazard logic stay inline.

Test Plan:
- Reset then feed addi $1,$0,-5 (0x2001FFFB) with pc_plus1=1:
  - two edges later, id_valid=1, id_imm_ext=0xFFFFFFFB, id_alu_src=1, id_reg_write=1, id_rt=1.
- Write-back $3=0xDEADBEEF in the same cycle IF/ID holds add $4,$3,$3:
  - id_rs_data = id_rt_data = 0xDEADBEEF (bypass).
  - wb_addr=0 with data 0x1234: $0 still reads 0.
- lw $2,0($1) followed by add $5,$2,$2:
  - hazard_stall=1 for exactly one cycle and IF/ID holds.
  - A bubble (id_valid=0) appears, then the add issues with id_rs=2.
- Assert flush while beq sits in ID/EX and a younger instruction sits in IF/ID:
  - next cycle id_valid=0; the following cycle, after a new instruction is fetched, valid is restored.
- stall=1 for 3 cycles with sw in IF/ID:
  - 3 bubbles, then sw emerges once with id_mem_write=1; no duplicate and no loss.
- Opcode 0x3F:
  - id_illegal=1, id_valid=1, all controls 0.
  - Assert rst_n low mid-stream: all outputs go 0 asynchronously, before the next clock edge.
